// File: rtl/aes_core_multikey.sv
// AES-128/192/256 encrypt core: iterative key expansion into a word store, then one
// round per cycle with a valid/ready handshake on both sides.
module aes_core_multikey #(
  parameter int unsigned MAX_KEY_BITS = 256
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [255:0] key_in,
  input  logic [1:0]   key_len,
  input  logic         key_load,
  output logic         key_ready,
  output logic         key_err,
  input  logic [127:0] data_in,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [127:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);

  if (!(MAX_KEY_BITS == 128 || MAX_KEY_BITS == 192 || MAX_KEY_BITS == 256)) begin : gen_bad_max
    $error("MAX_KEY_BITS must be 128, 192 or 256");
  end

  localparam logic [0:255][7:0] SBox = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBox[w[31:24]], SBox[w[23:16]], SBox[w[15:8]], SBox[w[7:0]]};
  endfunction

  // Byte k of the block sits at bits [127-8k -: 8]; row r, column c is byte r+4c.
  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(r+4*c) -: 8] = SBox[s[127-8*(r+4*((c+r)%4)) -: 8]];
      end
    end
    return o;
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  typedef enum logic {KIdle, KExp} kst_e;
  typedef enum logic [1:0] {EIdle, ERound, EDone} est_e;

  kst_e kst_q, kst_d;
  est_e est_q, est_d;

  logic [31:0]  w_q [60];
  logic [5:0]   ki_q, kmod_q, nk_q, nk_new;
  logic [3:0]   nr_q, nr_new, round_q, rk_round;
  logic [7:0]   rcon_q;
  logic         key_ready_q, key_err_q, out_valid_q;
  logic [127:0] state_q, out_data_q;
  logic         key_ok, key_acc, in_fire, kexp_last;
  logic [31:0]  w_prev, w_back, temp, w_new;
  logic [5:0]   rk_base;
  logic [127:0] rk, sb, full_rnd;

  always_comb begin
    key_ok = 1'b0;
    nk_new = 6'd4;
    nr_new = 4'd10;
    unique case (key_len)
      2'b00: key_ok = 1'b1;
      2'b01: begin key_ok = (MAX_KEY_BITS >= 192); nk_new = 6'd6; nr_new = 4'd12; end
      2'b10: begin key_ok = (MAX_KEY_BITS >= 256); nk_new = 6'd8; nr_new = 4'd14; end
      default: key_ok = 1'b0;
    endcase
  end

  // Key-expansion recurrence for word ki_q; kmod_q tracks ki_q mod Nk.
  always_comb begin
    w_prev = w_q[ki_q - 6'd1];
    w_back = w_q[ki_q - nk_q];
    temp   = w_prev;
    if (kmod_q == 6'd0) begin
      temp = sub_word({w_prev[23:0], w_prev[31:24]}) ^ {rcon_q, 24'h0};
    end else if (nk_q == 6'd8 && kmod_q == 6'd4) begin
      temp = sub_word(w_prev);
    end
    w_new     = w_back ^ temp;
    kexp_last = (ki_q == {nr_q, 2'b11});
  end

  always_comb begin
    rk_round = (est_q == EIdle) ? 4'd0 : round_q;
    rk_base  = {rk_round, 2'b00};
    rk       = {w_q[rk_base], w_q[rk_base + 6'd1], w_q[rk_base + 6'd2], w_q[rk_base + 6'd3]};
    sb       = sub_shift(state_q);
    full_rnd = {mix_col(sb[127:96]), mix_col(sb[95:64]), mix_col(sb[63:32]), mix_col(sb[31:0])}
               ^ rk;
  end

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      kst_q <= KIdle;
      est_q <= EIdle;
    end else begin
      kst_q <= kst_d;
      est_q <= est_d;
    end
  end

  // Next-state logic
  always_comb begin
    kst_d = kst_q;
    est_d = est_q;
    unique case (kst_q)
      KIdle:   if (key_acc && key_ok) kst_d = KExp;
      KExp:    if (kexp_last) kst_d = KIdle;
      default: kst_d = KIdle;
    endcase
    unique case (est_q)
      EIdle:   if (in_fire) est_d = ERound;
      ERound:  if (round_q == nr_q) est_d = EDone;
      EDone:   if (out_ready) est_d = EIdle;
      default: est_d = EIdle;
    endcase
  end

  // Outputs / handshakes; a key_load that can be taken wins over a block.
  always_comb begin
    key_acc  = key_load && kst_q == KIdle && est_q == EIdle && !out_valid_q;
    in_ready = est_q == EIdle && key_ready_q && kst_q == KIdle;
    in_fire  = in_valid && in_ready && !key_load;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      key_ready_q <= 1'b0;
      key_err_q   <= 1'b0;
      ki_q        <= '0;
      kmod_q      <= '0;
      nk_q        <= '0;
      nr_q        <= '0;
      rcon_q      <= 8'h01;
    end else begin
      key_err_q <= key_acc && !key_ok;
      if (key_acc && key_ok) begin
        key_ready_q <= 1'b0;
        ki_q        <= nk_new;
        kmod_q      <= '0;
        nk_q        <= nk_new;
        nr_q        <= nr_new;
        rcon_q      <= 8'h01;
      end else if (kst_q == KExp) begin
        ki_q   <= ki_q + 6'd1;
        kmod_q <= (kmod_q == nk_q - 6'd1) ? 6'd0 : kmod_q + 6'd1;
        if (kmod_q == 6'd0) rcon_q <= xtime(rcon_q);
        if (kexp_last) key_ready_q <= 1'b1;
      end
    end
  end

  // Key store: not reset, unreachable until key_ready is set again.
  always_ff @(posedge clk) begin
    if (key_acc && key_ok && !rst) begin
      for (int i = 0; i < 8; i++) w_q[i] <= key_in[255-32*i -: 32];
    end else if (kst_q == KExp && !rst) begin
      w_q[ki_q] <= w_new;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= '0;
      round_q     <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      unique case (est_q)
        EIdle: if (in_fire) begin
          state_q <= data_in ^ rk;
          round_q <= 4'd1;
        end
        ERound: if (round_q == nr_q) begin
          out_data_q  <= sb ^ rk;
          out_valid_q <= 1'b1;
        end else begin
          state_q <= full_rnd;
          round_q <= round_q + 4'd1;
        end
        EDone: if (out_ready) out_valid_q <= 1'b0;
        default: ;
      endcase
    end
  end

  assign key_ready = key_ready_q;
  assign key_err   = key_err_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_aes_core_multikey.sv
// Directed bench for aes_core_multikey: FIPS-197 vectors, timing, backpressure,
// key errors, load priority and mid-operation reset.
module tb_aes_core_multikey;

  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] key_in;
  logic [1:0]   key_len;
  logic         key_load;
  logic         key_ready;
  logic         key_err;
  logic [127:0] data_in;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] out_data;
  logic         out_valid;
  logic         out_ready;

  int checks = 0;
  int errors = 0;

  localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
  localparam logic [255:0] K256 =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] PT128 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT128 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;

  aes_core_multikey #(.MAX_KEY_BITS(256)) dut (
    .clk       (clk),
    .rst       (rst),
    .key_in    (key_in),
    .key_len   (key_len),
    .key_load  (key_load),
    .key_ready (key_ready),
    .key_err   (key_err),
    .data_in   (data_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  // Stimulus helpers: they only measure, the test tasks compare.
  task automatic do_load(input logic [255:0] k, input logic [1:0] len, output int edges);
    @(negedge clk);
    key_in = k; key_len = len; key_load = 1'b1;
    @(posedge clk);
    @(negedge clk);
    key_load = 1'b0;
    edges = 0;
    while (!key_ready && edges < 100) begin
      @(posedge clk); edges++;
      @(negedge clk);
    end
  endtask

  task automatic do_encrypt(input logic [127:0] pt, output logic rdy, output int lat,
                            output logic [127:0] ct);
    @(negedge clk);
    rdy = in_ready;
    data_in = pt; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    data_in = '1;
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk); lat++;
      @(negedge clk);
    end
    ct = out_data;
  endtask

  task automatic do_ack(output logic rdy_during, output logic vld_after, output logic rdy_after);
    @(negedge clk);
    out_ready = 1'b1;
    rdy_during = in_ready;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    vld_after = out_valid;
    rdy_after = in_ready;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (key_ready !== 1'b0) begin errors++; $display("FAIL reset_key_ready got %b want 0", key_ready); end
    checks++; if (key_err !== 1'b0) begin errors++; $display("FAIL reset_key_err got %b want 0", key_err); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    checks++; if (out_data !== 128'h0) begin errors++; $display("FAIL reset_out_data got %h want 0", out_data); end
    rst = 1'b0;
  endtask

  task automatic test_aes128;
    int e, l; logic r, rd, va, ra; logic [127:0] ct;
    do_load(K128, 2'b00, e);
    checks++; if (e !== 40) begin errors++; $display("FAIL k128_edges got %0d want 40", e); end
    key_len = 2'b10;  // live input must not affect round count
    do_encrypt(PT128, r, l, ct);
    checks++; if (r !== 1'b1) begin errors++; $display("FAIL k128_in_ready got %b want 1", r); end
    checks++; if (l !== 10) begin errors++; $display("FAIL k128_latency got %0d want 10", l); end
    checks++; if (ct !== CT128) begin errors++; $display("FAIL k128_ct got %h want %h", ct, CT128); end
    do_ack(rd, va, ra);
    checks++; if (va !== 1'b0) begin errors++; $display("FAIL k128_ack_valid got %b want 0", va); end
  endtask

  task automatic test_backpressure;
    int l; logic r, rd, va, ra; logic [127:0] ct;
    int bad;
    do_encrypt(PT128, r, l, ct);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_data !== CT128 || in_ready !== 1'b0) begin
        errors++; bad++;
        if (bad < 4) $display("FAIL bp_hold cycle %0d got v=%b d=%h rdy=%b want v=1 d=%h rdy=0",
                              i, out_valid, out_data, in_ready, CT128);
      end
    end
    do_ack(rd, va, ra);
    checks++; if (rd !== 1'b0) begin errors++; $display("FAIL bp_rdy_during_ack got %b want 0", rd); end
    checks++; if (va !== 1'b0) begin errors++; $display("FAIL bp_valid_after got %b want 0", va); end
    checks++; if (ra !== 1'b1) begin errors++; $display("FAIL bp_rdy_after got %b want 1", ra); end
  endtask

  task automatic test_aes192;
    int e, l; logic r, rd, va, ra; logic [127:0] ct;
    do_load(K192, 2'b01, e);
    checks++; if (e !== 46) begin errors++; $display("FAIL k192_edges got %0d want 46", e); end
    do_encrypt(PT, r, l, ct);
    checks++; if (l !== 12) begin errors++; $display("FAIL k192_latency got %0d want 12", l); end
    checks++; if (ct !== CT192) begin errors++; $display("FAIL k192_ct got %h want %h", ct, CT192); end
    do_ack(rd, va, ra);
  endtask

  task automatic test_aes256;
    int e, l; logic r, rd, va, ra; logic [127:0] ct;
    do_load(K256, 2'b10, e);
    checks++; if (e !== 52) begin errors++; $display("FAIL k256_edges got %0d want 52", e); end
    do_encrypt(PT, r, l, ct);
    checks++; if (l !== 14) begin errors++; $display("FAIL k256_latency got %0d want 14", l); end
    checks++; if (ct !== CT256) begin errors++; $display("FAIL k256_ct got %h want %h", ct, CT256); end
    do_ack(rd, va, ra);
  endtask

  task automatic test_key_priority;
    int n; logic seen_valid; int l; logic r, rd, va, ra; logic [127:0] ct;
    @(negedge clk);
    key_in = K128; key_len = 2'b00; key_load = 1'b1;
    data_in = PT128; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    key_load = 1'b0; in_valid = 1'b0;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL prio_in_ready got %b want 0", in_ready); end
    n = 0; seen_valid = 1'b0;
    while (!key_ready && n < 100) begin
      @(posedge clk); n++;
      @(negedge clk);
      if (out_valid) seen_valid = 1'b1;
    end
    checks++; if (n !== 40) begin errors++; $display("FAIL prio_edges got %0d want 40", n); end
    checks++; if (seen_valid !== 1'b0) begin errors++; $display("FAIL prio_block_taken got %b want 0", seen_valid); end
    do_encrypt(PT128, r, l, ct);
    checks++; if (ct !== CT128) begin errors++; $display("FAIL prio_ct got %h want %h", ct, CT128); end
    do_ack(rd, va, ra);
  endtask

  task automatic test_key_err;
    int l; logic r, rd, va, ra; logic [127:0] ct;
    @(negedge clk);
    key_in = '1; key_len = 2'b11; key_load = 1'b1;
    @(posedge clk);
    @(negedge clk);
    key_load = 1'b0;
    checks++; if (key_err !== 1'b1) begin errors++; $display("FAIL kerr_pulse got %b want 1", key_err); end
    checks++; if (key_ready !== 1'b1) begin errors++; $display("FAIL kerr_ready got %b want 1", key_ready); end
    @(posedge clk);
    @(negedge clk);
    checks++; if (key_err !== 1'b0) begin errors++; $display("FAIL kerr_width got %b want 0", key_err); end
    do_encrypt(PT128, r, l, ct);
    checks++; if (ct !== CT128) begin errors++; $display("FAIL kerr_ct got %h want %h", ct, CT128); end
    do_ack(rd, va, ra);
  endtask

  task automatic test_reset_mid_round;
    int e, l; logic r, rd, va, ra; logic [127:0] ct; logic seen_valid;
    @(negedge clk);
    data_in = PT128; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    seen_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid) seen_valid = 1'b1;
    end
    checks++; if (seen_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b want 0", seen_valid); end
    checks++; if (key_ready !== 1'b0) begin errors++; $display("FAIL rst_key_ready got %b want 0", key_ready); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %b want 0", in_ready); end
    do_load(K128, 2'b00, e);
    checks++; if (e !== 40) begin errors++; $display("FAIL rst_reload_edges got %0d want 40", e); end
    do_encrypt(PT128, r, l, ct);
    checks++; if (ct !== CT128) begin errors++; $display("FAIL rst_rerun_ct got %h want %h", ct, CT128); end
    checks++; if (l !== 10) begin errors++; $display("FAIL rst_rerun_latency got %0d want 10", l); end
    do_ack(rd, va, ra);
  endtask

  initial begin
    rst = 1'b1; key_in = '0; key_len = 2'b00; key_load = 1'b0;
    data_in = '0; in_valid = 1'b0; out_ready = 1'b0;
    test_reset;
    test_aes128;
    test_backpressure;
    test_aes192;
    test_aes256;
    test_key_priority;
    test_key_err;
    test_reset_mid_round;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
